uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver stage directly upstream of the UART application logic.
- Takes the raw RX line from the HPS loan-IO input pin, then synchronises, oversamples and deframes 8N1 characters.
- Presents each received byte through a one-entry holding register with a valid/ready handshake.
- Reports framing errors and overrun to the consumer.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit; must be 16 (tick-index rules below assume it).
- DIV, CLK_HZ/(BAUD*OVERSAMPLE) rounded to nearest (27 by default), clocks per sample tick; derived, not overridden.

Ports:
- clk_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- RX_LINE  in  1  raw serial input, idle high, asynchronous to clk_50.
- rx_data  out  8  received byte, LSB-first reassembled; stable while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- overrun  out  1  sticky; set when a byte completes while the holding register is full.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - FSM=IDLE, synchroniser flops=1, tick and bit counters=0.
- Synchroniser: two flops on RX_LINE; all decisions use the second flop (rx_s), giving 2-cycle input latency.
- Tick generator:
  - Counter 0..DIV-1; tick asserts for one clk when the count equals DIV-1.
  - Reset to 0 on start detection so ticks are phase-aligned to the falling edge.
- Per bit, a sample index s counts 0..15 on ticks.
- Majority vote of rx_s at s=7,8,9; the decision is taken on the s=9 tick.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s=0 -> START; clear s, the tick counter and the bit counter.
  - START: at s=9, majority=1 -> IDLE (glitch rejected, no output); at s=15 tick -> DATA.
  - DATA:
    - At s=9, shift the majority bit into the shift register MSB (LSB-first line order).
    - At s=15, increment the bit counter.
    - After bit 7 completes -> STOP.
  - STOP:
    - At s=9, majority=1: byte complete; majority=0: frame_err pulses on the next cycle and the byte is discarded.
    - Either way -> IDLE at the same tick, so back-to-back characters with a one-bit stop are captured.
- Byte completion with holding register empty, or being emptied in the same cycle (rx_valid & rx_ready):
  - rx_data loads the shift register; rx_valid=1 on the next clk.
  - Simultaneous accept and load leaves rx_valid=1 with the new byte.
- Byte completion with holding register full and rx_ready=0:
  - The new byte is dropped; rx_data keeps the old byte.
  - overrun is set on the next clk.
- Accept with no new byte: rx_valid clears on the next clk.
- overrun_clr has priority below set: if set and clear coincide, overrun stays 1.
- Latency from the RX_LINE mid-stop-bit (s=9 tick) to rx_valid=1: one clk after the tick, plus 2 synchroniser clks relative to the pin.
- RX_LINE held low (break): start validates, data=0x00, stop fails -> frame_err. The FSM then waits in IDLE, restarting only on rx_s=0 after at least one observed high sample; a continuous break yields exactly one frame_err.
- Reset asserted mid-character: all state is cleared immediately. After release, the receiver hunts for a fresh falling edge, so the remainder of the interrupted frame may be misparsed or flagged as a framing error.

Decomposition:
- Package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP).
  - Constants SAMPLE_MID=8, VOTE_LO=7, VOTE_HI=9, LAST_SAMPLE=15, DATA_BITS=8.
  - Divider-rounding function used to compute DIV.
- Sub-module uart_baud_gen:
  - Parameter DIV.
  - Inputs clk_50, reset, restart; output tick.
  - Shareable later with the transmitter.
- Synchroniser, vote, FSM and holding register stay in uart_rx.

Test Plan:
- Byte 0x55 at 115200 baud (434 clk/bit), rx_ready=1 -> one rx_valid pulse with rx_data=0x55; frame_err=0, overrun=0.
- RX_LINE low for 120 clk (less than half a bit) then high -> no rx_valid, no frame_err; FSM returns to IDLE.
- Byte 0xA3 with stop bit driven low -> frame_err one-cycle pulse, rx_valid stays 0, rx_data unchanged.
- 0x12 then 0x34 back-to-back with rx_ready=0 -> rx_valid=1, rx_data=0x12, overrun=1.
  - Raise rx_ready, then pulse overrun_clr -> rx_valid=0, overrun=0.
- Bytes 0x00, 0xFF, 0x81 at +2% and -2% baud skew, rx_ready=1 -> all three received exactly, no errors.
- reset asserted at bit 4 of 0xC3 for 3 clk, then 0x5A sent -> outputs 0 during reset; next valid byte equals 0x5A, with any interrupted-frame residue limited to a frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Desc     : Shared UART receiver encodings, sample-index constants and the
//            clock-divider rounding helper.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [3:0] SAMPLE_MID  = 4'd8;
  localparam logic [3:0] VOTE_LO     = 4'd7;
  localparam logic [3:0] VOTE_HI     = 4'd9;
  localparam logic [3:0] LAST_SAMPLE = 4'd15;
  localparam int         DATA_BITS   = 8;

  // Clocks per sample tick, rounded to nearest.
  function automatic int div_round(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Desc     : Sample-tick generator; one-clock tick every DIV clocks, phase
//            restartable so ticks align to a detected edge.
// Revision : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
  parameter int DIV = 27
) (
  input  logic clk_50,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int                c_cnt_w    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == c_last_cnt)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last_cnt);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Desc     : 8N1 receiver: two-flop synchroniser, 16x oversampling with 3-sample
//            majority vote, one-entry holding register with valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       RX_LINE,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       overrun_clr
);

  localparam int         DIV        = div_round(CLK_HZ, BAUD, OVERSAMPLE);
  localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);

  logic       r_sync1, r_rx_s;
  rx_state_t  r_state, w_state_next;
  logic [3:0] r_s;
  logic [2:0] r_bit_cnt;
  logic [1:0] r_votes;
  logic [7:0] r_shreg;
  logic       r_armed;
  logic       w_tick, w_restart, w_maj, w_mid_tick, w_end_tick;
  logic       w_byte_done, w_stop_fail;
  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_frame_err, r_overrun;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= RX_LINE;
      r_rx_s  <= r_sync1;
    end
  end

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk_50  (clk_50),
    .reset   (reset),
    .restart (w_restart),
    .tick    (w_tick)
  );

  assign w_maj      = (r_votes[0] & r_votes[1]) | (r_votes[0] & r_rx_s) | (r_votes[1] & r_rx_s);
  assign w_mid_tick = w_tick && (r_s == VOTE_HI);
  assign w_end_tick = w_tick && (r_s == LAST_SAMPLE);

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A start is only accepted once the line has been seen high since the last
  // frame ended, so a held-low break produces a single framing error.
  always_comb begin
    w_state_next = r_state;
    w_restart    = 1'b0;
    w_byte_done  = 1'b0;
    w_stop_fail  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s && r_armed) begin
          w_state_next = START;
          w_restart    = 1'b1;
        end
      end
      START: begin
        if (w_mid_tick && w_maj) begin
          w_state_next = IDLE;
        end else if (w_end_tick) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_end_tick && (r_bit_cnt == c_last_bit)) begin
          w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_mid_tick) begin
          w_state_next = IDLE;
          w_byte_done  = w_maj;
          w_stop_fail  = !w_maj;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_s       <= '0;
      r_bit_cnt <= '0;
      r_votes   <= '0;
      r_shreg   <= '0;
      r_armed   <= 1'b0;
    end else begin
      if (w_restart) begin
        r_s       <= '0;
        r_bit_cnt <= '0;
      end else if (w_tick && (r_state != IDLE)) begin
        r_s <= r_s + 4'd1;
        if (r_s == VOTE_LO)    r_votes[0] <= r_rx_s;
        if (r_s == SAMPLE_MID) r_votes[1] <= r_rx_s;
        if ((r_state == DATA) && (r_s == VOTE_HI))     r_shreg   <= {w_maj, r_shreg[7:1]};
        if ((r_state == DATA) && (r_s == LAST_SAMPLE)) r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_restart || ((r_state == STOP) && w_mid_tick)) begin
        r_armed <= 1'b0;
      end else if ((r_state == IDLE) && r_rx_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_fail;
      if (w_byte_done && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= r_shreg;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (w_byte_done && r_rx_valid && !rx_ready) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire
